// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a byte-addressable SRAM, with configurable OKAY wait states
// and a two-cycle ERROR response. A write commits at the edge that ends its data phase.
module ahb_lite_sram_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 0,
  parameter int HRESP_W     = 2
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [3:0]          HPROT,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic [HRESP_W-1:0]  HRESP,
  output logic [DATA_W-1:0]   HRDATA
);
  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int WORDS  = MEM_BYTES / NB;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int OFF_W  = LANE_W + IDX_W;
  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               wr_pend;
  logic [OFF_W-1:0]   dp_off;
  logic [2:0]         dp_size;
  logic               hready_r, herr_r;
  logic [DATA_W-1:0]  rdata_r;
  logic [DATA_W-1:0]  mem [WORDS];

  logic               accept, bad, commit;
  logic [ADDR_W-1:0]  amask;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic [NB-1:0]      be;
  logic [DATA_W-1:0]  rd_word;
  logic               unused_ok;

  assign unused_ok = ^{HTRANS[0], HBURST, HPROT};

  // Only sample address phases while this slave is itself ready.
  assign accept = HSEL && HREADY && HTRANS[1] && hready_r;
  assign amask  = ~({ADDR_W{1'b1}} << HSIZE);
  assign bad    = ({1'b0, HADDR} >= MEM_LIM) || (HSIZE > 3'(LANE_W)) || ((HADDR & amask) != '0);
  assign commit = (state == S_IDLE) && wr_pend;
  assign wr_idx = dp_off[LANE_W +: IDX_W];
  assign rd_idx = HADDR[LANE_W +: IDX_W];

  always_comb begin
    be = '0;
    for (int b = 0; b < NB; b++)
      be[b] = (b >= int'(dp_off[LANE_W-1:0])) &&
              (b < int'(dp_off[LANE_W-1:0]) + (1 << dp_size));
  end

  // Bypass: a read accepted on the write's completing edge sees the new bytes.
  always_comb begin
    rd_word = mem[rd_idx];
    for (int b = 0; b < NB; b++)
      if (commit && (wr_idx == rd_idx) && be[b])
        rd_word[8*b +: 8] = HWDATA[8*b +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (commit && !HRESET)
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wr_pend  <= 1'b0;
      dp_off   <= '0;
      dp_size  <= '0;
      hready_r <= 1'b1;
      herr_r   <= 1'b0;
      rdata_r  <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERR2: begin
          state    <= S_IDLE;
          hready_r <= 1'b1;
          herr_r   <= 1'b0;
          wr_pend  <= 1'b0;
          if (accept) begin
            dp_off  <= HADDR[OFF_W-1:0];
            dp_size <= HSIZE;
            if (bad) begin
              state    <= S_ERR1;
              hready_r <= 1'b0;
              herr_r   <= 1'b1;
              rdata_r  <= '0;
            end else begin
              wr_pend <= HWRITE;
              rdata_r <= HWRITE ? '0 : rd_word;
              if (WAIT_STATES > 0) begin
                state    <= S_WAIT;
                cnt      <= 4'(WAIT_STATES);
                hready_r <= 1'b0;
              end
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= S_IDLE;
            hready_r <= 1'b1;
          end
        end
        S_ERR1: begin
          state    <= S_ERR2;
          hready_r <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign HREADYOUT = hready_r;
  assign HRESP     = herr_r ? HRESP_W'(1) : '0;
  assign HRDATA    = rdata_r;
endmodule
